// File: rtl/aes_sbox_pipe.sv
// aes_sbox_pipe: LANES-wide AES forward/inverse S-box behind a STAGES-deep
// elastic valid/ready pipeline. The mode bit travels with every word.
module aes_sbox_pipe #(
   parameter int LANES  = 4,
   parameter int STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_inv,
   input  logic [8*LANES-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_inv,
   output logic [8*LANES-1:0] out_data
);
   localparam int W = 8 * LANES;

   // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // Multiplicative inverse as x^254 (= x^2 * x^4 * ... * x^128); maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] s;
      r = 8'h01;
      s = x;
      for (int i = 1; i < 8; i++) begin
         s = gf_mul(s, s);
         r = gf_mul(r, s);
      end
      return r;
   endfunction

   function automatic logic [7:0] affine_fwd(input logic [7:0] a);
      return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^
             {a[3:0], a[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] affine_inv(input logic [7:0] b);
      return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x, input logic inv);
      if (inv) return gf_inv(affine_inv(x));
      return affine_fwd(gf_inv(x));
   endfunction

   logic [STAGES-1:0]        vld_q, vld_d;
   logic [STAGES-1:0]        inv_q, inv_d;
   logic [STAGES-1:0][W-1:0] data_q, data_d;
   logic [STAGES-1:0]        load;
   logic [STAGES-1:0]        src_vld, src_inv;
   logic [STAGES-1:0][W-1:0] src_data;
   logic [W-1:0]             sub_word;

   always_comb begin
      sub_word = '0;
      for (int i = 0; i < LANES; i++) begin
         sub_word[8*i +: 8] = sbox(in_data[8*i +: 8], in_inv);
      end
   end

   // Stall chain: a stage may load if empty or if the stage after it loads.
   always_comb begin
      logic down_ok;
      down_ok = out_ready;
      load    = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         load[k] = !vld_q[k] || down_ok;
         down_ok = load[k];
      end
   end

   always_comb begin
      src_vld     = '0;
      src_inv     = '0;
      src_data    = '0;
      src_vld[0]  = in_valid;
      src_inv[0]  = in_inv;
      src_data[0] = sub_word;
      for (int k = 1; k < STAGES; k++) begin
         src_vld[k]  = vld_q[k-1];
         src_inv[k]  = inv_q[k-1];
         src_data[k] = data_q[k-1];
      end
   end

   // Data registers only capture real words so held contents stay put.
   always_comb begin
      vld_d  = vld_q;
      inv_d  = inv_q;
      data_d = data_q;
      for (int k = 0; k < STAGES; k++) begin
         if (load[k]) vld_d[k] = src_vld[k];
         if (load[k] && src_vld[k]) begin
            inv_d[k]  = src_inv[k];
            data_d[k] = src_data[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= '0;
         inv_q  <= '0;
         data_q <= '0;
      end else begin
         vld_q  <= vld_d;
         inv_q  <= inv_d;
         data_q <= data_d;
      end
   end

   assign in_ready  = load[0] && !rst;
   assign out_valid = vld_q[STAGES-1];
   assign out_inv   = inv_q[STAGES-1];
   assign out_data  = data_q[STAGES-1];

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// tb_aes_sbox_pipe: three configurations of aes_sbox_pipe (4x2, 1x1, 16x4)
// checked against a FIPS-197 table model built from field arithmetic.
module tb_aes_sbox_pipe;
   localparam int ND = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_s  [ND];
   logic         iv_s   [ND];
   logic         ir_s   [ND];
   logic         ii_s   [ND];
   logic [127:0] id_s   [ND];
   logic         ov_s   [ND];
   logic         ordy_s [ND];
   logic         oi_s   [ND];
   logic [31:0]  od0;
   logic [7:0]   od1;
   logic [127:0] od2;

   aes_sbox_pipe #(.LANES(4), .STAGES(2)) u0 (
      .clk(clk), .rst(rst_s[0]), .in_valid(iv_s[0]), .in_ready(ir_s[0]),
      .in_inv(ii_s[0]), .in_data(id_s[0][31:0]), .out_valid(ov_s[0]),
      .out_ready(ordy_s[0]), .out_inv(oi_s[0]), .out_data(od0));
   aes_sbox_pipe #(.LANES(1), .STAGES(1)) u1 (
      .clk(clk), .rst(rst_s[1]), .in_valid(iv_s[1]), .in_ready(ir_s[1]),
      .in_inv(ii_s[1]), .in_data(id_s[1][7:0]), .out_valid(ov_s[1]),
      .out_ready(ordy_s[1]), .out_inv(oi_s[1]), .out_data(od1));
   aes_sbox_pipe #(.LANES(16), .STAGES(4)) u2 (
      .clk(clk), .rst(rst_s[2]), .in_valid(iv_s[2]), .in_ready(ir_s[2]),
      .in_inv(ii_s[2]), .in_data(id_s[2]), .out_valid(ov_s[2]),
      .out_ready(ordy_s[2]), .out_inv(oi_s[2]), .out_data(od2));

   typedef struct {
      logic [127:0] data;
      logic         inv;
      int           cyc;
   } item_t;

   item_t      exp_q  [$];
   item_t      stim_q [$];
   logic [7:0] fwd_tab [256];
   logic [7:0] inv_tab [256];
   int         errors = 0;
   int         checks = 0;

   function automatic int lanes_of(input int d);
      return (d == 0) ? 4 : (d == 1) ? 1 : 16;
   endfunction

   function automatic int stages_of(input int d);
      return (d == 0) ? 2 : (d == 1) ? 1 : 4;
   endfunction

   function automatic logic [127:0] get_out(input int d);
      case (d)
         0:       return {96'h0, od0};
         1:       return {120'h0, od1};
         default: return od2;
      endcase
   endfunction

   // Carry-less product followed by long-division reduction by 0x11B.
   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   function automatic void build_tables();
      logic [7:0] c;
      logic [7:0] a;
      logic [7:0] b;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         a = 8'h00;
         for (int y = 1; y < 256; y++) if (m_mul(8'(x), 8'(y)) == 8'h01) a = 8'(y);
         for (int j = 0; j < 8; j++)
            b[j] = a[j] ^ a[(j+4)%8] ^ a[(j+5)%8] ^ a[(j+6)%8] ^ a[(j+7)%8] ^ c[j];
         fwd_tab[x] = b;
         inv_tab[b] = 8'(x);
      end
   endfunction

   function automatic logic [127:0] model_word(input logic [127:0] v, input logic inv,
                                               input int lanes);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < lanes; i++)
         r[8*i +: 8] = inv ? inv_tab[v[8*i +: 8]] : fwd_tab[v[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rand_word(input int d);
      logic [127:0] v;
      v = {$urandom, $urandom, $urandom, $urandom};
      return v & ((128'h1 << (8 * lanes_of(d))) - 128'h1);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Generic streaming engine: feeds stim_q, checks order, hold and latency.
   task automatic run_stream(input int d, input int n, input int vpct, input int rpct,
                             input bit lat_chk, input string tag);
      int           sent, got, cyc, limit;
      bit           hold_prev;
      logic [127:0] hold_data, od;
      logic         hold_inv;
      item_t        e, it;
      exp_q.delete();
      sent = 0; got = 0; cyc = 0; hold_prev = 0;
      hold_data = '0; hold_inv = 1'b0;
      limit = 20 * n + 200;
      while ((sent < n || exp_q.size() != 0) && cyc < limit) begin
         if (sent < n && $urandom_range(99) < vpct) begin
            iv_s[d] = 1'b1;
            id_s[d] = stim_q[sent].data;
            ii_s[d] = stim_q[sent].inv;
         end else begin
            iv_s[d] = 1'b0;
         end
         ordy_s[d] = ($urandom_range(99) < rpct);
         @(negedge clk);
         od = get_out(d);
         if (hold_prev) begin
            checks++;
            if (ov_s[d] !== 1'b1 || od !== hold_data || oi_s[d] !== hold_inv) begin
               errors++;
               $display("FAIL %s_hold dut%0d: got v=%b %h inv=%b, need v=1 %h inv=%b",
                        tag, d, ov_s[d], od, oi_s[d], hold_data, hold_inv);
            end
         end
         if (ov_s[d] === 1'b1 && ordy_s[d]) begin
            checks++;
            got++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL %s_extra dut%0d: got unexpected word %h, need none", tag, d, od);
            end else begin
               e = exp_q.pop_front();
               if (od !== e.data || oi_s[d] !== e.inv ||
                   (lat_chk && (cyc - e.cyc) != stages_of(d))) begin
                  errors++;
                  $display("FAIL %s_data dut%0d: got %h inv=%b lat=%0d, need %h inv=%b lat=%0d",
                           tag, d, od, oi_s[d], cyc - e.cyc, e.data, e.inv, stages_of(d));
               end
            end
         end
         hold_prev = (ov_s[d] === 1'b1) && !ordy_s[d];
         hold_data = od;
         hold_inv  = oi_s[d];
         if (iv_s[d] && ir_s[d] === 1'b1) begin
            it.data = model_word(id_s[d], ii_s[d], lanes_of(d));
            it.inv  = ii_s[d];
            it.cyc  = cyc;
            exp_q.push_back(it);
            sent++;
         end
         tick();
         cyc++;
      end
      iv_s[d]   = 1'b0;
      ordy_s[d] = 1'b1;
      checks++;
      if (sent != n || got != n || exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_count dut%0d: got sent=%0d out=%0d left=%0d, need %0d/%0d/0",
                  tag, d, sent, got, exp_q.size(), n, n);
      end
   endtask

   task automatic test_reset();
      for (int d = 0; d < ND; d++) begin
         rst_s[d] = 1'b1; iv_s[d] = 1'b1; id_s[d] = rand_word(d); ordy_s[d] = 1'b1;
      end
      tick();
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         checks++;
         if (ov_s[d] !== 1'b0 || get_out(d) !== '0 || oi_s[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_out dut%0d: got v=%b d=%h i=%b, need 0 0 0",
                     d, ov_s[d], get_out(d), oi_s[d]);
         end
         checks++;
         if (ir_s[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready dut%0d: got %b, need 0", d, ir_s[d]);
         end
      end
      tick();
      for (int d = 0; d < ND; d++) begin
         rst_s[d] = 1'b0; iv_s[d] = 1'b0;
      end
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         checks++;
         if (ir_s[d] !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready dut%0d: got %b, need 1", d, ir_s[d]);
         end
      end
      tick();
   endtask

   task automatic test_known();
      logic [31:0] want [5];
      logic        wv   [5];
      logic        wi   [5];
      want[0] = 32'h0; want[1] = 32'h0; want[2] = 32'h7C16ED63;
      want[3] = 32'h01FF5300; want[4] = 32'h0;
      wv[0] = 1'b0; wv[1] = 1'b0; wv[2] = 1'b1; wv[3] = 1'b1; wv[4] = 1'b0;
      wi[0] = 1'b0; wi[1] = 1'b0; wi[2] = 1'b0; wi[3] = 1'b1; wi[4] = 1'b0;
      ordy_s[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         iv_s[0] = (k < 2);
         id_s[0] = (k == 0) ? 128'h01FF5300 : 128'h7C16ED63;
         ii_s[0] = (k == 1);
         @(negedge clk);
         checks++;
         if (ov_s[0] !== wv[k] || (wv[k] && (od0 !== want[k] || oi_s[0] !== wi[k])) ||
             (k < 2 && ir_s[0] !== 1'b1)) begin
            errors++;
            $display("FAIL known_vec cyc%0d: got v=%b %h inv=%b rdy=%b, need v=%b %h inv=%b",
                     k, ov_s[0], od0, oi_s[0], ir_s[0], wv[k], want[k], wi[k]);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      item_t it;
      stim_q.delete();
      for (int w = 0; w < 16; w++) begin
         it.data = rand_word(0); it.inv = w[0]; it.cyc = 0;
         stim_q.push_back(it);
      end
      run_stream(0, 16, 100, 100, 1'b1, "b2b");
   endtask

   task automatic test_backpressure();
      item_t it, e;
      exp_q.delete();
      ordy_s[0] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         iv_s[0] = 1'b1; id_s[0] = rand_word(0); ii_s[0] = $urandom_range(1);
         @(negedge clk);
         checks++;
         if (ir_s[0] !== (k < 2)) begin
            errors++;
            $display("FAIL bp_fill_ready cyc%0d: got %b, need %b", k, ir_s[0], (k < 2));
         end
         if (k >= 2) begin
            checks++;
            if (ov_s[0] !== 1'b1 || {96'h0, od0} !== exp_q[0].data || oi_s[0] !== exp_q[0].inv) begin
               errors++;
               $display("FAIL bp_held cyc%0d: got v=%b %h, need v=1 %h",
                        k, ov_s[0], od0, exp_q[0].data);
            end
         end
         if (ir_s[0] === 1'b1) begin
            it.data = model_word(id_s[0], ii_s[0], 4); it.inv = ii_s[0]; it.cyc = 0;
            exp_q.push_back(it);
         end
         tick();
      end
      ordy_s[0] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         iv_s[0] = (k < 4); id_s[0] = rand_word(0); ii_s[0] = $urandom_range(1);
         @(negedge clk);
         if (k < 4) begin
            checks++;
            if (ir_s[0] !== 1'b1 || ov_s[0] !== 1'b1) begin
               errors++;
               $display("FAIL bp_flow cyc%0d: got rdy=%b v=%b, need 1 1", k, ir_s[0], ov_s[0]);
            end
         end
         if (ov_s[0] === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL bp_extra: got word %h, need none", od0);
            end else begin
               e = exp_q.pop_front();
               if ({96'h0, od0} !== e.data || oi_s[0] !== e.inv) begin
                  errors++;
                  $display("FAIL bp_data: got %h inv=%b, need %h inv=%b", od0, oi_s[0], e.data, e.inv);
               end
            end
         end
         if (iv_s[0] && ir_s[0] === 1'b1) begin
            it.data = model_word(id_s[0], ii_s[0], 4); it.inv = ii_s[0]; it.cyc = 0;
            exp_q.push_back(it);
         end
         tick();
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL bp_drain: got %0d words left, need 0", exp_q.size());
      end
   endtask

   task automatic test_reset_in_flight();
      item_t it;
      ordy_s[0] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         iv_s[0] = 1'b1; id_s[0] = rand_word(0); ii_s[0] = $urandom_range(1);
         tick();
      end
      rst_s[0] = 1'b1; ordy_s[0] = 1'b1;
      @(negedge clk);
      checks++;
      if (ir_s[0] !== 1'b0) begin
         errors++;
         $display("FAIL rst_flight_ready: got %b during reset, need 0", ir_s[0]);
      end
      tick();
      rst_s[0] = 1'b0; iv_s[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (ov_s[0] !== 1'b0 || od0 !== 32'h0 || oi_s[0] !== 1'b0 || ir_s[0] !== 1'b1) begin
         errors++;
         $display("FAIL rst_flight_clear: got v=%b d=%h i=%b rdy=%b, need 0 0 0 1",
                  ov_s[0], od0, oi_s[0], ir_s[0]);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (ov_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_flight_stale cyc%0d: got out_valid=%b, need 0", k, ov_s[0]);
         end
         tick();
      end
      stim_q.delete();
      for (int w = 0; w < 6; w++) begin
         it.data = rand_word(0); it.inv = $urandom_range(1); it.cyc = 0;
         stim_q.push_back(it);
      end
      run_stream(0, 6, 100, 100, 1'b1, "post_rst");
   endtask

   task automatic test_stream_all(input int d);
      int    off [16];
      item_t it;
      int    v;
      for (int i = 0; i < 16; i++) off[i] = $urandom_range(255);
      stim_q.delete();
      for (int w = 0; w < 512; w++) begin
         v = w >> 1;
         it.data = '0;
         for (int i = 0; i < lanes_of(d); i++) it.data[8*i +: 8] = 8'((v + off[i]) % 256);
         it.inv = w[0];
         it.cyc = 0;
         stim_q.push_back(it);
      end
      run_stream(d, 512, 80, 50, 1'b0, "stream");
   endtask

   task automatic test_latency(input int d);
      item_t it;
      stim_q.delete();
      for (int w = 0; w < 24; w++) begin
         it.data = rand_word(d); it.inv = $urandom_range(1); it.cyc = 0;
         stim_q.push_back(it);
      end
      run_stream(d, 24, 100, 100, 1'b1, "latency");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < ND; d++) begin
         rst_s[d] = 1'b0; iv_s[d] = 1'b0; ii_s[d] = 1'b0; id_s[d] = '0; ordy_s[d] = 1'b1;
      end
      build_tables();
      test_reset();
      test_known();
      test_back_to_back();
      test_backpressure();
      test_reset_in_flight();
      for (int d = 0; d < ND; d++) test_stream_all(d);
      test_latency(1);
      test_latency(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
